// File: rtl/regfile64x32_wr.sv
// Write side of the 32 x 64-bit integer register file: capture stage, one-hot commit decoder, storage.
// Optional REGFILE_ZERO_REG_EN hardwires register 31 to zero and drops writes addressed to it.
module regfile64x32_wr #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [4:0]                  wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [DEPTH-1:0][WIDTH-1:0] data_out,
    output logic                        pend_valid,
    output logic [4:0]                  pend_addr,
    output logic [WIDTH-1:0]            pend_data
);

    logic                 capture_en;
    logic [DEPTH-1:0]     commit_en;
    logic [WIDTH-1:0]     regs [DEPTH];

`ifdef REGFILE_ZERO_REG_EN
    // Writes to the zero register never enter the pipeline, so nothing nonzero is ever forwarded for X31.
    assign capture_en = wr_en && (wr_addr != 5'd31);
`else
    assign capture_en = wr_en;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= capture_en;
            if (capture_en) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
        end
    end

    always_comb begin
        commit_en = '0;
        for (int j = 0; j < DEPTH; j++) begin
            commit_en[j] = pend_valid && (pend_addr == 5'(j));
        end
    end

    // Reset wins over a pending commit, so a write captured just before reset is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                regs[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (commit_en[j]) begin
                    regs[j] <= pend_data;
                end
            end
`ifdef REGFILE_ZERO_REG_EN
            regs[DEPTH-1] <= '0;
`endif
        end
    end

    always_comb begin
        data_out = '0;
        for (int j = 0; j < DEPTH; j++) begin
            data_out[j] = regs[j];
        end
    end

endmodule

// File: tb/tb_regfile64x32_wr.sv
// Self-checking bench for regfile64x32_wr: vector table plus hand sequences, scoreboard of expected pending state.
// Honours REGFILE_ZERO_REG_EN the same way the design does.
module tb_regfile64x32_wr;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [63:0]         wr_data;
    logic [31:0][63:0]   data_out;
    logic                pend_valid;
    logic [4:0]          pend_addr;
    logic [63:0]         pend_data;

    regfile64x32_wr #(.WIDTH(64), .DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .data_out   (data_out),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        check_payload;
    } pend_t;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        exp_pv;
    } vec_t;

    pend_t       exp_q[$];
    pend_t       model_pend;
    logic [63:0] model [32];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic captures(input logic en, input logic [4:0] a);
`ifdef REGFILE_ZERO_REG_EN
        return en && (a != 5'd31);
`else
        return en;
`endif
    endfunction

    task automatic checkPend();
        pend_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        checkOutput("pend_valid", 64'(pend_valid), 64'(e.valid));
        if (e.valid || e.check_payload) begin
            checkOutput("pend_addr", 64'(pend_addr), 64'(e.addr));
            checkOutput("pend_data", pend_data, e.data);
        end
        for (int j = 0; j < 32; j++) begin
            checkOutput($sformatf("data_out[%0d]", j), data_out[j], model[j]);
        end
    endtask

    // One clock: drive at negedge, advance the model, push expected pending state, check after the edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic [4:0] a, input logic [63:0] d);
        pend_t nxt;
        @(negedge clk);
        reset   = rst;
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        if (rst) begin
            for (int j = 0; j < 32; j++) model[j] = 64'd0;
            nxt = '{1'b0, 5'd0, 64'd0, 1'b1};
        end else begin
            if (model_pend.valid) model[model_pend.addr] = model_pend.data;
            nxt.valid         = captures(en, a);
            nxt.addr          = a;
            nxt.data          = d;
            nxt.check_payload = 1'b0;
        end
        model_pend = nxt;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        checkPend();
    endtask

    vec_t vecs [7];

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 64'd0;
        model_pend = '{1'b0, 5'd0, 64'd0, 1'b0};
        for (int j = 0; j < 32; j++) model[j] = 64'd0;

        vecs[0] = '{1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005, 1'b1};
        vecs[1] = '{1'b0, 5'd0, 64'd0, 1'b0};
        vecs[2] = '{1'b1, 5'd3, 64'd1, 1'b1};
        vecs[3] = '{1'b1, 5'd3, 64'd2, 1'b1};
        vecs[4] = '{1'b1, 5'd7, 64'd3, 1'b1};
        vecs[5] = '{1'b0, 5'd0, 64'd0, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 64'd0, 1'b0};

        applyStimulus(1'b1, 1'b0, 5'd0, 64'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 64'd0);

        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b0, 1'b1, 5'(j * 3), {$urandom, $urandom});
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 64'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 64'd0);
        for (int j = 0; j < 32; j++) checkOutput("reset_zero", data_out[j], 64'd0);
        checkOutput("reset_pv", 64'(pend_valid), 64'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, vecs[i].en, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("tbl_pv[%0d]", i), 64'(pend_valid), 64'(vecs[i].exp_pv));
            if (i == 1) checkOutput("single_wr_reg5", data_out[5], 64'hDEAD_BEEF_0000_0005);
        end
        checkOutput("b2b_reg3", data_out[3], 64'd2);
        checkOutput("b2b_reg7", data_out[7], 64'd3);

        for (int j = 0; j < 31; j++) begin
            applyStimulus(1'b0, 1'b1, 5'(j), 64'(j) + 64'h100);
        end
        applyStimulus(1'b0, 1'b1, 5'd31, 64'h131);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("sweep_reg0", data_out[0], 64'h100);
        checkOutput("sweep_reg30", data_out[30], 64'h11E);
`ifdef REGFILE_ZERO_REG_EN
        checkOutput("sweep_reg31", data_out[31], 64'd0);
`else
        checkOutput("sweep_reg31", data_out[31], 64'h131);
`endif

        applyStimulus(1'b0, 1'b1, 5'd9, 64'hFF);
        checkOutput("midrst_capture", 64'(pend_valid), 64'd1);
        applyStimulus(1'b1, 1'b0, 5'd0, 64'd0);
        checkOutput("midrst_reg9", data_out[9], 64'd0);
        checkOutput("midrst_pv", 64'(pend_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 64'd0);
        checkOutput("midrst_reg9_later", data_out[9], 64'd0);

        applyStimulus(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef REGFILE_ZERO_REG_EN
        checkOutput("x31_pv", 64'(pend_valid), 64'd0);
`else
        checkOutput("x31_pv", 64'(pend_valid), 64'd1);
`endif
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 5'd0, 64'd0);
`ifdef REGFILE_ZERO_REG_EN
        checkOutput("x31_reg31", data_out[31], 64'd0);
`else
        checkOutput("x31_reg31", data_out[31], 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
